// File: rtl/ula_mc.sv
// ula_mc: multi-cycle ALU with start/busy/done handshake, registered result
// and flags. Single-cycle logic, add/sub, compare and shift ops finish in
// one clock; MUL (shift-add) and DIVU (restoring) iterate for WIDTH clocks.
// Ports: clk, reset (sync, active high), start, SrcA, SrcB, ULAControl in;
//        ULAResult, FlagZ, FlagC, busy, done out.
module ula_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ULAControl,
    output logic [WIDTH-1:0] ULAResult,
    output logic             FlagZ,
    output logic             FlagC,
    output logic             busy,
    output logic             done
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] hi, hi_n;
    logic [WIDTH-1:0] lo, lo_n;
    logic [WIDTH-1:0] opnd, opnd_n;
    logic             is_div, is_div_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0] res_n;
    logic             z_n, c_n, done_n;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic [WIDTH:0]   ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;

    // Single-cycle operations.
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        ext   = '0;
        case (ULAControl)
            4'b0000: alu_r = SrcA & SrcB;
            4'b0001: alu_r = SrcA | SrcB;
            4'b0010: begin
                ext   = {1'b0, SrcA} + {1'b0, SrcB};
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
            end
            4'b0011: alu_r = ~(SrcA | SrcB);
            4'b0100: alu_r = SrcA ^ SrcB;
            4'b0101: begin
                // Top bit of the extended difference is the borrow.
                ext   = {1'b0, SrcA} - {1'b0, SrcB};
                alu_r = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
            end
            4'b0110: alu_r = WIDTH'(SrcA < SrcB);
            4'b0111: alu_r = WIDTH'(SrcA == SrcB);
            4'b1000: alu_r = SrcA << SrcB[SHW-1:0];
            4'b1001: alu_r = SrcA >> SrcB[SHW-1:0];
            default: ;
        endcase
    end

    // Iterative datapath. MUL: {carry,hi,lo} holds partial product and the
    // multiplier, shifted right each step. DIVU: hi is the remainder, lo
    // shifts the dividend out and the quotient bits in.
    always_comb begin
        sum  = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
        shl  = {hi, lo[WIDTH-1]};
        diff = shl - {1'b0, opnd};
    end

    always_comb begin
        state_n  = state;
        hi_n     = hi;
        lo_n     = lo;
        opnd_n   = opnd;
        is_div_n = is_div;
        cnt_n    = cnt;
        res_n    = ULAResult;
        z_n      = FlagZ;
        c_n      = FlagC;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (ULAControl == OP_MUL || ULAControl == OP_DIVU) begin
                        is_div_n = (ULAControl == OP_DIVU);
                        hi_n     = '0;
                        lo_n     = is_div_n ? SrcA : SrcB;
                        opnd_n   = is_div_n ? SrcB : SrcA;
                        cnt_n    = '0;
                        state_n  = RUN;
                    end else begin
                        res_n  = alu_r;
                        z_n    = (alu_r == '0);
                        c_n    = alu_c;
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (is_div) begin
                    if (!diff[WIDTH]) begin
                        hi_n = diff[WIDTH-1:0];
                        lo_n = {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_n = shl[WIDTH-1:0];
                        lo_n = {lo[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_n = sum[WIDTH:1];
                    lo_n = {sum[0], lo[WIDTH-1:1]};
                end
                cnt_n = cnt + 1'b1;
                if (cnt == SHW'(WIDTH - 1)) begin
                    res_n   = lo_n;
                    z_n     = (lo_n == '0);
                    // Divide by zero naturally yields all ones.
                    c_n     = is_div ? (opnd == '0) : (hi_n != '0);
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            cnt       <= '0;
            ULAResult <= '0;
            FlagZ     <= 1'b0;
            FlagC     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            hi        <= hi_n;
            lo        <= lo_n;
            opnd      <= opnd_n;
            is_div    <= is_div_n;
            cnt       <= cnt_n;
            ULAResult <= res_n;
            FlagZ     <= z_n;
            FlagC     <= c_n;
            done      <= done_n;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_ula_mc.sv
// tb_ula_mc: scoreboard bench for ula_mc. Driver pushes model results for
// accepted starts; a negedge monitor pops on done and checks hold otherwise.
module tb_ula_mc;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [3:0]   ULAControl;
    logic [W-1:0] ULAResult;
    logic         FlagZ;
    logic         FlagC;
    logic         busy;
    logic         done;

    ula_mc #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .SrcA(SrcA),
        .SrcB(SrcB),
        .ULAControl(ULAControl),
        .ULAResult(ULAResult),
        .FlagZ(FlagZ),
        .FlagC(FlagC),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        int           due;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           vectors = 0;
    int           miscompares = 0;
    int           edges = 0;
    int           run_lo = 0;
    int           run_hi = -1;
    bit           mon_en = 1'b0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;
    logic         last_c = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        int unsigned ua   = a;
        int unsigned ub   = b;
        int unsigned mask = (1 << W) - 1;
        int unsigned v    = 0;
        logic        c    = 1'b0;
        exp_t        e;
        case (op)
            4'd0:  v = ua & ub;
            4'd1:  v = ua | ub;
            4'd2:  begin v = ua + ub; c = (v > mask); end
            4'd3:  v = ~(ua | ub) & mask;
            4'd4:  v = ua ^ ub;
            4'd5:  begin v = (ua - ub) & mask; c = (ua < ub); end
            4'd6:  v = (ua < ub) ? 1 : 0;
            4'd7:  v = (ua == ub) ? 1 : 0;
            4'd8:  v = (ua << (ub % W)) & mask;
            4'd9:  v = ua >> (ub % W);
            4'd10: begin v = ua * ub; c = (v > mask); end
            4'd11: begin
                if (ub == 0) begin v = mask; c = 1'b1; end
                else v = ua / ub;
            end
            default: v = 0;
        endcase
        e.r   = W'(v & mask);
        e.z   = (e.r == '0);
        e.c   = c;
        e.due = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && edges > q[0].due) begin
                vectors++;
                miscompares++;
                $display("FAIL latency: no done by edge %0d (now %0d)",
                         q[0].due, edges);
                void'(q.pop_front());
            end
            chk("busy", 32'(busy),
                32'(edges >= run_lo && edges <= run_hi));
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done: got done=1, expected 0");
                end else begin
                    mon_e = q.pop_front();
                    chk("result", 32'(ULAResult), 32'(mon_e.r));
                    chk("flag_z", 32'(FlagZ), 32'(mon_e.z));
                    chk("flag_c", 32'(FlagC), 32'(mon_e.c));
                    chk("done_edge", edges, mon_e.due);
                    last_r = mon_e.r;
                    last_z = mon_e.z;
                    last_c = mon_e.c;
                end
            end else begin
                chk("done_low", 32'(done), 32'd0);
                chk("hold_result", 32'(ULAResult), 32'(last_r));
                chk("hold_z", 32'(FlagZ), 32'(last_z));
                chk("hold_c", 32'(FlagC), 32'(last_c));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        ULAControl = op;
        SrcA       = a;
        SrcB       = b;
        if (edges >= run_hi + 1) begin
            e = model(op, a, b);
            if (op == 4'b1010 || op == 4'b1011) begin
                e.due  = edges + 1 + W;
                run_lo = edges + 1;
                run_hi = edges + W;
            end else begin
                e.due = edges + 1;
            end
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_free();
        while (edges < run_hi) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset      = 1'b1;
        start      = 1'b0;
        SrcA       = '0;
        SrcB       = '0;
        ULAControl = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", 32'(ULAResult), 32'd0);
        chk("rst_z", 32'(FlagZ), 32'd0);
        chk("rst_c", 32'(FlagC), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        issue(4'b0010, 8'hFF, 8'h01);
        issue(4'b0101, 8'h03, 8'h05);
        issue(4'b0110, 8'h03, 8'h05);
        issue(4'b0111, 8'h07, 8'h07);
        issue(4'b0011, 8'hF0, 8'h0F);
        issue(4'b1000, 8'h81, 8'h09);
        issue(4'b1001, 8'h81, 8'h0F);
        issue(4'b1100, 8'h12, 8'h34);
        issue(4'b1111, 8'hFF, 8'hFF);

        wait_free();
        issue(4'b1010, 8'd15, 8'd17);
        wait_free();
        issue(4'b1010, 8'd16, 8'd16);
        wait_free();
        issue(4'b1011, 8'd200, 8'd7);
        wait_free();
        issue(4'b1011, 8'd5, 8'd0);

        wait_free();
        issue(4'b1010, 8'd13, 8'd11);
        issue(4'b0010, 8'hAA, 8'h55);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            SrcA  = W'($urandom);
            SrcB  = W'($urandom);
        end
        wait_free();
        issue(4'b0100, 8'h3C, 8'h5A);
        issue(4'b0000, 8'h3C, 8'h5A);
        idle(2);

        wait_free();
        issue(4'b1011, 8'd200, 8'd7);
        idle(3);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        run_lo = 0;
        run_hi = -1;
        last_r = '0;
        last_z = 1'b0;
        last_c = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(ULAResult), 32'd0);
        reset = 1'b0;
        issue(4'b1011, 8'd200, 8'd7);
        wait_free();
        idle(1);

        repeat (300) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = W'($urandom);
            if ($urandom_range(0, 5) == 0) b = '0;
            if ($urandom_range(0, 2) != 0) wait_free();
            issue(op, a, b);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        wait_free();
        idle(3);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ula_mc.md
# ula_mc

Multi-cycle, width-parametrised arithmetic/logic unit and successor to the 8-bit combinational ULA. It sits in the datapath between the register-file read ports and the write-back mux. It adds a start/busy/done handshake, registered results and flags, carry/borrow reporting, shifts, and iterative unsigned multiply and divide. Single-cycle operations complete in one clock; MUL and DIVU run a WIDTH-cycle iterative engine.

## Interface
- WIDTH, 8: operand/result width; power of two, 4..32.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on clk only while busy=0.
- SrcA  input  WIDTH  operand A; sampled with an accepted start.
- SrcB  input  WIDTH  operand B; sampled with an accepted start.
- ULAControl  input  4  operation code; sampled with an accepted start.
- ULAResult  output  WIDTH  registered result.
- FlagZ  output  1  registered; 1 when ULAResult == 0.
- FlagC  output  1  registered carry/borrow/overflow, per operation.
- busy  output  1  high while the iterative engine runs.
- done  output  1  one-cycle pulse when ULAResult and the flags update.

## Operation
- Opcodes (A, B are the latched operands):
  - 0000 AND
  - 0001 OR
  - 0010 ADD: C = carry-out
  - 0011 NOR = ~(A|B)
  - 0100 XOR
  - 0101 SUB = A-B: C = borrow (A<B unsigned)
  - 0110 SLTU: result 1 if A<B unsigned, else 0
  - 0111 SEQ: result 1 if A==B, else 0
  - 1000 SLL: A << B[SHW-1:0]
  - 1001 SRL: A >> B[SHW-1:0] (logical)
  - 1010 MUL: low WIDTH bits of A*B; C = 1 if the high half is non-zero
  - 1011 DIVU: quotient A/B, remainder discarded
  - 1100-1111: result 0
- FlagC = 0 for every opcode that does not define it above.
- DIVU with B=0: result all ones, FlagC=1. DIVU with B!=0: FlagC=0.
- FlagZ always reflects the final ULAResult, including opcodes 1100-1111 (Z=1).
- State machine:
  - IDLE (busy=0). start=1 with a single-cycle opcode: compute, register result and flags, pulse done, stay in IDLE. start=1 with MUL/DIVU: latch operands, clear the accumulator and iteration counter, go to RUN.
  - RUN (busy=1). One shift-add (MUL) or restoring shift-subtract (DIVU) step per cycle. After WIDTH steps: register result and flags, pulse done, return to IDLE.
- start while busy=1 is ignored, along with the operands presented with it.
- start in the cycle done=1 is accepted, because busy is already 0.
- ULAResult, FlagZ and FlagC hold their value between done pulses. Operand changes after acceptance have no effect.
- reset: ULAResult=0, FlagZ=0, FlagC=0, busy=0, done=0, state IDLE. Reset in RUN aborts the operation with no done pulse. Reset has priority over start in the same cycle.

## Timing
- Edge numbering: start is sampled high at edge T.
- Single-cycle ops: outputs valid and done=1 after edge T, for exactly one cycle. Latency is 1.
- MUL/DIVU: busy=1 after edges T..T+WIDTH-1. After edge T+WIDTH, busy=0, done=1 and the outputs are valid. Latency is WIDTH cycles.
- Back-to-back single-cycle ops: a new start every cycle gives done every cycle.
- Iterative results are bit-exact with the mathematical unsigned values. There is no dependence on operand timing after acceptance.

## Test plan
- Reset, then ADD 0xFF+0x01 (WIDTH=8) -> after 1 cycle ULAResult=0x00, Z=1, C=1, done pulse of 1 cycle; reset values all 0 beforehand.
- SUB 0x03-0x05 -> 0xFE, Z=0, C=1. SLTU 3,5 -> 1. SEQ 7,7 -> 1. NOR 0xF0,0x0F -> 0x00, Z=1. SLL 0x81 by 0x09 (shift 1) -> 0x02.
- MUL 15*17 -> 0xFF, C=0; MUL 16*16 -> 0x00, Z=1, C=1. For both, busy is high 8 cycles and done arrives at cycle 8.
- DIVU 200/7 -> 0x1C, C=0; DIVU 5/0 -> 0xFF, C=1. Latency 8 cycles.
- During MUL, pulse start with ADD and alter the operands -> ignored, MUL result unchanged. start in the done cycle is accepted.
- Reset asserted mid-DIVU (cycle 4) -> busy=0 and outputs 0 next cycle, no done pulse. A new start afterwards computes correctly.
